// File: rtl/seek_match_window_counter.sv
// Counts "101" detector matches over fixed windows, emits one result per window.
// Optional SEEK_WIN_INDEX_EN adds a 16-bit window index output.
module seek_match_window_counter #(
  parameter int WINDOW_LEN = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic             match,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
`ifdef SEEK_WIN_INDEX_EN
  output logic [15:0]      out_win_idx,
`endif
  output logic             out_dropped
);

  localparam int CYC_W = $clog2(WINDOW_LEN);
  localparam logic [CYC_W-1:0] LAST = CYC_W'(WINDOW_LEN - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0]       state;
  logic [CYC_W-1:0] cyc;
  logic [CNT_W-1:0] acc;
  logic             sat;
  logic             drop_pending;

  logic             acc_full;
  logic [CNT_W-1:0] sum;
  logic             sum_sat;
  logic             win_end;
  logic             load;
  logic             drop;

  assign acc_full = &acc;
  assign sum      = (match && !acc_full) ? acc + CNT_W'(1) : acc;
  assign sum_sat  = sat | (match & acc_full);
  assign win_end  = (state == ACCUM) && enable && (cyc == LAST);
  assign load     = win_end && (!out_valid || out_ready);
  assign drop     = win_end && out_valid && !out_ready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      cyc   <= '0;
      acc   <= '0;
      sat   <= 1'b0;
    end else if (state == IDLE) begin
      if (enable) begin
        state <= ACCUM;
        cyc   <= CYC_W'(1);
        acc   <= CNT_W'(match);
        sat   <= 1'b0;
      end
    end else if (!enable) begin
      state <= IDLE;
      cyc   <= '0;
      acc   <= '0;
      sat   <= 1'b0;
    end else if (win_end) begin
      cyc <= '0;
      acc <= '0;
      sat <= 1'b0;
    end else begin
      cyc <= cyc + CYC_W'(1);
      acc <= sum;
      sat <= sum_sat;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid    <= 1'b0;
      out_count    <= '0;
      out_sat      <= 1'b0;
      out_dropped  <= 1'b0;
      drop_pending <= 1'b0;
    end else begin
      if (load) begin
        out_valid    <= 1'b1;
        out_count    <= sum;
        out_sat      <= sum_sat;
        out_dropped  <= drop_pending;
        drop_pending <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // Sticky until the next result that actually loads
      if (drop) begin
        drop_pending <= 1'b1;
      end
    end
  end

`ifdef SEEK_WIN_INDEX_EN
  logic [15:0] win_idx;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      win_idx     <= '0;
      out_win_idx <= '0;
    end else begin
      if (win_end) begin
        win_idx <= win_idx + 16'd1;
      end
      if (load) begin
        out_win_idx <= win_idx;
      end
    end
  end
`endif

endmodule
